pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 1-bit full adder: a WIDTH-bit add/subtract unit with carry-in and carry-out.
- The carry chain is split into STAGES equal slices, with one register stage per slice.
- Valid/ready handshakes on both sides carry operand and result streams.
- Used wherever a wide add must meet timing and the caller can tolerate a fixed latency.

---
 rtl/pipe_adder_if.sv | 41 ++++
 rtl/pipe_adder.sv | 124 ++++++++++++
 tb/tb_pipe_adder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result stream bundle for pipe_adder.
// The slave modport is the adder itself. The master modport is whoever
// feeds operands and drains results.
// ovf exists only when PIPE_ADDER_OVERFLOW_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef PIPE_ADDER_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit with carry-in and carry-out.
//
// The carry chain is cut into STAGES slices of SW = WIDTH/STAGES bits, with
// one register stage per slice. Stage k adds slice k of the operands to the
// carry that stage k-1 registered. Operand bits that are not yet consumed
// travel alongside as skew. Result slices that are already finished travel
// alongside as deskew. Because every stage registers full-width copies,
// the same datapath works for any STAGES, including STAGES = 1.
//
// The whole pipe stalls globally whenever a result is presented and not
// taken. This gives latency STAGES and one beat per cycle when unstalled.
//
// Optional feature: define PIPE_ADDER_OVERFLOW_EN to add the signed-overflow
// output ovf. ovf is registered alongside the final result slice.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);

    localparam int SW = WIDTH / STAGES;

    logic             advance;

    // Stage registers; index k holds what stage k produced.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    // Stage inputs and combinational slice results.
    logic             v_in  [STAGES];
    logic             cy_in [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic [SW:0]      slice [STAGES];
    logic             c_nx  [STAGES];
    logic [WIDTH-1:0] s_nx  [STAGES];

    assign advance       = ~v_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.c_out     = c_q[STAGES-1];

    // Per-stage input selection and slice addition.
    // Stage 0 conditions the operands for subtract.
    // Each later stage takes the previous stage's registers.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                v_in[k]  = bus.in_valid;
                cy_in[k] = bus.c_in ^ bus.sub;
                a_in[k]  = bus.a;
                b_in[k]  = bus.sub ? ~bus.b : bus.b;
                s_in[k]  = '0;
            end else begin
                v_in[k]  = v_q[(k > 0) ? k - 1 : 0];
                cy_in[k] = c_q[(k > 0) ? k - 1 : 0];
                a_in[k]  = a_q[(k > 0) ? k - 1 : 0];
                b_in[k]  = b_q[(k > 0) ? k - 1 : 0];
                s_in[k]  = s_q[(k > 0) ? k - 1 : 0];
            end
            slice[k] = {1'b0, a_in[k][k*SW +: SW]}
                     + {1'b0, b_in[k][k*SW +: SW]}
                     + {{SW{1'b0}}, cy_in[k]};
            c_nx[k]  = slice[k][SW];
            s_nx[k]  = s_in[k];
            s_nx[k][k*SW +: SW] = slice[k][SW-1:0];
        end
    end

    // Pipeline registers.
    // All stages advance together and are cleared on reset, so no stale
    // beat survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                c_q[k] <= c_nx[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVERFLOW_EN
    localparam int MSB = WIDTH - 1;

    logic ovf_q;
    logic ovf_nx;

    // The skew registers still hold the operand MSBs that were captured at
    // accept, so overflow is formed in the final stage next to the result MSB.
    assign ovf_nx = (a_in[STAGES-1][MSB] == b_in[STAGES-1][MSB])
                  & (s_nx[STAGES-1][MSB] != a_in[STAGES-1][MSB]);

    // Overflow flag register, aligned with sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_nx;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed, table-driven bench for pipe_adder (WIDTH=32, STAGES=4).
// Vector expectations are hand-computed constants.
// Also covers the PIPE_ADDER_OVERFLOW_EN build.
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int NV     = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic dut_ovf;
`ifdef PIPE_ADDER_OVERFLOW_EN
    assign dut_ovf = bus.ovf;
`else
    assign dut_ovf = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
        int          cyc;
    } res_t;

    vec_t vecs [NV];
    res_t rq [$];
    int   n_pass   = 0;
    int   n_checks = 0;
    int   cyc      = 0;

    // Record every result transfer with the cycle it happened in.
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            rq.push_back('{bus.sum, bus.c_out, dut_ovf, cyc});
        end
        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic drive(input int idx, input logic vld);
        bus.in_valid = vld;
        bus.a        = vecs[idx].a;
        bus.b        = vecs[idx].b;
        bus.c_in     = vecs[idx].c_in;
        bus.sub      = vecs[idx].sub;
    endtask

    // One isolated beat: out_valid must rise exactly STAGES-1 edges after the accept edge.
    task automatic single_beat(input int idx);
        @(negedge clk);
        drive(idx, 1'b1);
        #1 check($sformatf("accept_ready[%0d]", idx), bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int e = 0; e < STAGES; e++) begin
            @(negedge clk);
            check($sformatf("latency_valid[%0d] e%0d", idx, e), bus.out_valid, (e == STAGES - 1));
        end
        check($sformatf("latency_sum[%0d]", idx), bus.sum, vecs[idx].sum);
        check($sformatf("latency_cout[%0d]", idx), bus.c_out, vecs[idx].c_out);
`ifdef PIPE_ADDER_OVERFLOW_EN
        check($sformatf("latency_ovf[%0d]", idx), dut_ovf, vecs[idx].ovf);
`endif
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 60 && rq.size() < n; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("result_count", rq.size(), n);
    endtask

    task automatic compare_results(input int first, input int n, input logic consecutive);
        for (int i = 0; i < n && i < rq.size(); i++) begin
            check($sformatf("sum[%0d]", first + i), rq[i].sum, vecs[first + i].sum);
            check($sformatf("cout[%0d]", first + i), rq[i].c_out, vecs[first + i].c_out);
`ifdef PIPE_ADDER_OVERFLOW_EN
            check($sformatf("ovf[%0d]", first + i), rq[i].ovf, vecs[first + i].ovf);
`endif
            if (consecutive && i > 0)
                check($sformatf("back_to_back[%0d]", first + i), rq[i].cyc - rq[0].cyc, i);
        end
    endtask

    initial begin
        int exp8 [8];
        exp8 = '{0, 5, 8, 13, 16, 21, 24, 29};

        vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            vecs[1 + i] = '{iv, 32'(3 * i), iv[0], 1'b0, 32'(exp8[i]), 1'b0, 1'b0};
        end
        vecs[9]  = '{32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[10] = '{32'h7,         32'h5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[11] = '{32'h7,         32'h5,         1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
        vecs[12] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0};
        vecs[13] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[14] = '{32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[15] = '{32'h00FF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[16] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[17] = '{32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[18] = '{32'h3,         32'h4,         1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_sum", bus.sum, 0);
        check("reset_cout", bus.c_out, 0);
`ifdef PIPE_ADDER_OVERFLOW_EN
        check("reset_ovf", dut_ovf, 0);
`endif

        // Single beat with carry out of every slice.
        bus.out_ready = 1'b1;
        single_beat(0);
        repeat (2) @(negedge clk);
        rq.delete();

        // Back-to-back stream of the whole table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(i, 1'b1);
            #1 check($sformatf("in_ready_stream[%0d]", i), bus.in_ready, 1);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_results(NV);
        compare_results(0, NV, 1'b1);

        // Backpressure: stall three cycles with more beats in flight and one waiting.
        rq.delete();
        bus.out_ready = 1'b0;
        for (int i = 9; i <= 11; i++) begin
            @(negedge clk);
            drive(i, 1'b1);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int t = 0; t < 10 && !bus.out_valid; t++) @(negedge clk);
        check("stall_reached", bus.out_valid, 1);
        drive(12, 1'b1);
        for (int h = 0; h < 3; h++) begin
            #1;
            check($sformatf("stall_in_ready h%0d", h), bus.in_ready, 0);
            check($sformatf("stall_valid h%0d", h), bus.out_valid, 1);
            check($sformatf("stall_sum h%0d", h), bus.sum, vecs[9].sum);
            check($sformatf("stall_cout h%0d", h), bus.c_out, vecs[9].c_out);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 check("release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_results(4);
        compare_results(9, 4, 1'b0);

        // Reset with beats in flight.
        rq.delete();
        for (int i = 13; i <= 15; i++) begin
            @(negedge clk);
            drive(i, 1'b1);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1 check("reset_async_valid", bus.out_valid, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("post_reset_in_ready", bus.in_ready, 1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check($sformatf("post_reset_valid t%0d", t), bus.out_valid, 0);
        end
        check("post_reset_no_results", rq.size(), 0);
        single_beat(16);
        single_beat(17);
        single_beat(18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
